// File: rtl/pkt_sorter_if.sv
// Streaming bus bundle for pkt_sorter: sink (packet in), source (sorted packet out)
// and the side-band length/overflow status.
interface pkt_sorter_if #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned MAX_PKT_LEN = 32
);
  localparam int unsigned CW = $clog2(MAX_PKT_LEN) + 1;

  logic [DWIDTH-1:0] snk_data_i;
  logic              snk_startofpacket_i;
  logic              snk_endofpacket_i;
  logic              snk_valid_i;
  logic              snk_ready_o;
  logic [DWIDTH-1:0] src_data_o;
  logic              src_startofpacket_o;
  logic              src_endofpacket_o;
  logic              src_valid_o;
  logic              src_ready_i;
  logic [CW-1:0]     pkt_len_o;
  logic              overflow_o;

  // Sorter side
  modport slave (
    input  snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_valid_i, src_ready_i,
    output snk_ready_o, src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o,
    output pkt_len_o, overflow_o
  );

  // Producer/consumer side
  modport master (
    output snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_valid_i, src_ready_i,
    input  snk_ready_o, src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o,
    input  pkt_len_o, overflow_o
  );
endinterface

// File: rtl/pkt_sorter.sv
// pkt_sorter: collects one packet into a register array kept sorted by insertion
// (stable, parallel compare-and-shift) and streams it out in sorted order.
// Optional macro PKT_SORTER_SIGNED_EN: compare words as two's-complement signed.
module pkt_sorter #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned MAX_PKT_LEN = 32,
  parameter bit          DESCENDING  = 1'b0
) (
  input  logic         clk_i,
  input  logic         srst_i,
  pkt_sorter_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_PKT_LEN) + 1;
  localparam int unsigned AW = $clog2(MAX_PKT_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic              overflow_q, overflow_d;
  logic [DWIDTH-1:0] mem_q [MAX_PKT_LEN];
  logic [DWIDTH-1:0] mem_d [MAX_PKT_LEN];
  logic [DWIDTH-1:0] ins_c [MAX_PKT_LEN];
  logic [CW-1:0]     pos_c;
  logic              snk_beat_c, src_beat_c, full_c, last_c;

  // True when a stored word must stay ahead of the incoming word (ties keep arrival order)
  function automatic logic goes_after(input logic [DWIDTH-1:0] stored,
                                      input logic [DWIDTH-1:0] word);
`ifdef PKT_SORTER_SIGNED_EN
    if (DESCENDING) return ($signed(stored) >= $signed(word));
    return ($signed(stored) <= $signed(word));
`else
    if (DESCENDING) return (stored >= word);
    return (stored <= word);
`endif
  endfunction

  assign snk_beat_c = bus.snk_valid_i && bus.snk_ready_o;
  assign src_beat_c = bus.src_valid_o && bus.src_ready_i;
  assign full_c     = (count_q == CW'(MAX_PKT_LEN));
  assign last_c     = (rd_idx_q == (count_q - CW'(1)));

  // Insertion point is the length of the sorted prefix that stays ahead of the new word
  always_comb begin
    pos_c = '0;
    for (int unsigned i = 0; i < MAX_PKT_LEN; i++) begin
      if ((CW'(i) < count_q) && goes_after(mem_q[i], bus.snk_data_i)) begin
        pos_c = pos_c + CW'(1);
      end
    end
    ins_c[0] = (pos_c == '0) ? bus.snk_data_i : mem_q[0];
    for (int unsigned i = 1; i < MAX_PKT_LEN; i++) begin
      if (CW'(i) < pos_c) begin
        ins_c[i] = mem_q[i];
      end else if (CW'(i) == pos_c) begin
        ins_c[i] = bus.snk_data_i;
      end else begin
        ins_c[i] = mem_q[i-1];
      end
    end
  end

  // Next-state logic: fill, overflow-drop and drain sequencing
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = 1'b0;
    mem_d      = mem_q;
    unique case (state_q)
      S_IDLE: begin
        if (snk_beat_c && bus.snk_startofpacket_i) begin
          mem_d[0] = bus.snk_data_i;
          count_d  = CW'(1);
          state_d  = bus.snk_endofpacket_i ? S_DRAIN : S_FILL;
        end
      end
      S_FILL: begin
        if (snk_beat_c) begin
          if (bus.snk_startofpacket_i) begin
            mem_d[0] = bus.snk_data_i;
            count_d  = CW'(1);
            if (bus.snk_endofpacket_i) state_d = S_DRAIN;
          end else if (full_c) begin
            if (bus.snk_endofpacket_i) begin
              state_d    = S_DRAIN;
              overflow_d = 1'b1;
            end
          end else begin
            mem_d   = ins_c;
            count_d = count_q + CW'(1);
            if (bus.snk_endofpacket_i) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (src_beat_c) begin
          if (last_c) begin
            state_d  = S_IDLE;
            count_d  = '0;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + CW'(1);
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        count_d  = '0;
        rd_idx_d = '0;
      end
    endcase
  end

  // Control registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Data array needs no reset: entries are only read below count
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus.snk_ready_o         = (state_q != S_DRAIN);
  assign bus.src_valid_o         = (state_q == S_DRAIN);
  assign bus.src_data_o          = mem_q[AW'(rd_idx_q)];
  assign bus.src_startofpacket_o = (state_q == S_DRAIN) && (rd_idx_q == '0);
  assign bus.src_endofpacket_o   = (state_q == S_DRAIN) && last_c;
  assign bus.pkt_len_o           = (state_q == S_DRAIN) ? count_q : '0;
  assign bus.overflow_o          = overflow_q;

endmodule

// File: tb/tb_pkt_sorter.sv
// Directed bench for pkt_sorter: three instances (ascending, descending, short
// capacity) share one stimulus path selected by sel; expected sorted beats are
// queued when a packet is sent and popped as the sorter emits them.
module tb_pkt_sorter;

  logic       clk = 1'b0;
  logic       srst;
  logic [7:0] snk_data;
  logic       snk_sop, snk_eop, snk_valid, src_ready;
  int         sel;

  always #5 clk = ~clk;

  pkt_sorter_if #(.DWIDTH(8), .MAX_PKT_LEN(8)) if_asc ();
  pkt_sorter_if #(.DWIDTH(8), .MAX_PKT_LEN(8)) if_dsc ();
  pkt_sorter_if #(.DWIDTH(8), .MAX_PKT_LEN(4)) if_sml ();

  pkt_sorter #(.DWIDTH(8), .MAX_PKT_LEN(8), .DESCENDING(1'b0)) u_asc (.clk_i(clk), .srst_i(srst), .bus(if_asc));
  pkt_sorter #(.DWIDTH(8), .MAX_PKT_LEN(8), .DESCENDING(1'b1)) u_dsc (.clk_i(clk), .srst_i(srst), .bus(if_dsc));
  pkt_sorter #(.DWIDTH(8), .MAX_PKT_LEN(4), .DESCENDING(1'b0)) u_sml (.clk_i(clk), .srst_i(srst), .bus(if_sml));

  assign if_asc.snk_data_i          = snk_data;
  assign if_asc.snk_startofpacket_i = snk_sop;
  assign if_asc.snk_endofpacket_i   = snk_eop;
  assign if_asc.snk_valid_i         = snk_valid && (sel == 0);
  assign if_asc.src_ready_i         = src_ready && (sel == 0);
  assign if_dsc.snk_data_i          = snk_data;
  assign if_dsc.snk_startofpacket_i = snk_sop;
  assign if_dsc.snk_endofpacket_i   = snk_eop;
  assign if_dsc.snk_valid_i         = snk_valid && (sel == 1);
  assign if_dsc.src_ready_i         = src_ready && (sel == 1);
  assign if_sml.snk_data_i          = snk_data;
  assign if_sml.snk_startofpacket_i = snk_sop;
  assign if_sml.snk_endofpacket_i   = snk_eop;
  assign if_sml.snk_valid_i         = snk_valid && (sel == 2);
  assign if_sml.src_ready_i         = src_ready && (sel == 2);

  logic [7:0] o_data, o_len;
  logic       o_sop, o_eop, o_valid, o_ready, o_ovf;

  // Observe the selected instance
  always_comb begin
    case (sel)
      1: begin
        o_data = if_dsc.src_data_o; o_sop = if_dsc.src_startofpacket_o; o_eop = if_dsc.src_endofpacket_o;
        o_valid = if_dsc.src_valid_o; o_ready = if_dsc.snk_ready_o; o_ovf = if_dsc.overflow_o;
        o_len = 8'(if_dsc.pkt_len_o);
      end
      2: begin
        o_data = if_sml.src_data_o; o_sop = if_sml.src_startofpacket_o; o_eop = if_sml.src_endofpacket_o;
        o_valid = if_sml.src_valid_o; o_ready = if_sml.snk_ready_o; o_ovf = if_sml.overflow_o;
        o_len = 8'(if_sml.pkt_len_o);
      end
      default: begin
        o_data = if_asc.src_data_o; o_sop = if_asc.src_startofpacket_o; o_eop = if_asc.src_endofpacket_o;
        o_valid = if_asc.src_valid_o; o_ready = if_asc.snk_ready_o; o_ovf = if_asc.overflow_o;
        o_len = 8'(if_asc.pkt_len_o);
      end
    endcase
  end

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [7:0] len;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Queue the expected sorted output of an n-word packet
  task automatic exp_pkt(input int n, input logic [7:0] a0, a1, a2, a3);
    logic [7:0] v[4];
    exp_t e;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int i = 0; i < n; i++) begin
      e.d = v[i]; e.sop = (i == 0); e.eop = (i == n - 1); e.len = 8'(n);
      sb.push_back(e);
    end
  endtask

  // One sink beat, starting and ending on a falling edge
  task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
    int g;
    g = 0;
    snk_data = d; snk_sop = sop; snk_eop = eop; snk_valid = 1'b1;
    while (!o_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("snk_ready_timeout", 32'(o_ready), 32'd1);
    @(negedge clk);
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
  endtask

  // Whole packet with sop on first and eop on last word; first output due one cycle later
  task automatic send_pkt(input int n, input logic [7:0] a0, a1, a2, a3, a4, a5);
    logic [7:0] v[6];
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4; v[5] = a5;
    for (int i = 0; i < n; i++) beat(v[i], i == 0, i == n - 1);
    chk("first_valid_latency", 32'(o_valid), 32'd1);
  endtask

  // Consume the queued expectations; toggle=1 alternates src_ready 1/0
  task automatic drain(input bit toggle);
    int   guard;
    bit   rdy;
    exp_t e;
    guard = 0;
    rdy   = 1'b1;
    while (sb.size() > 0 && guard < 100) begin
      src_ready = rdy;
      e = sb[0];
      chk("src_valid", 32'(o_valid), 32'd1);
      chk("src_data", 32'(o_data), 32'(e.d));
      chk("src_sop", 32'(o_sop), 32'(e.sop));
      chk("src_eop", 32'(o_eop), 32'(e.eop));
      chk("pkt_len", 32'(o_len), 32'(e.len));
      if (rdy) void'(sb.pop_front());
      @(negedge clk);
      guard++;
      if (toggle) rdy = !rdy;
    end
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_snk_ready", 32'(o_ready), 32'd1);
    chk("idle_len", 32'(o_len), 32'd0);
    src_ready = 1'b1;
  endtask

  initial begin
    srst = 1'b1; snk_data = '0; snk_sop = 1'b0; snk_eop = 1'b0; snk_valid = 1'b0;
    src_ready = 1'b1; sel = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_len", 32'(o_len), 32'd0);
    chk("rst_ovf", 32'(o_ovf), 32'd0);
    srst = 1'b0;
    @(negedge clk);
    chk("rst_snk_ready", 32'(o_ready), 32'd1);

    // Ascending 5,3,9,1
    sel = 0;
    exp_pkt(4, 8'd1, 8'd3, 8'd5, 8'd9);
    send_pkt(4, 8'd5, 8'd3, 8'd9, 8'd1, 8'd0, 8'd0);
    chk("no_ovf", 32'(o_ovf), 32'd0);
    drain(1'b0);

    // Descending with duplicates, ready toggling
    sel = 1;
    exp_pkt(4, 8'd8, 8'd7, 8'd7, 8'd2);
    send_pkt(4, 8'd7, 8'd7, 8'd2, 8'd8, 8'd0, 8'd0);
    drain(1'b1);

    // Overflow: capacity 4, six words
    sel = 2;
    exp_pkt(4, 8'd3, 8'd4, 8'd5, 8'd6);
    send_pkt(6, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1);
    chk("ovf_pulse", 32'(o_ovf), 32'd1);
    src_ready = 1'b0;
    @(negedge clk);
    chk("ovf_one_cycle", 32'(o_ovf), 32'd0);
    drain(1'b0);

    // Single-word packet, stray non-sop beat, then restart mid-fill
    sel = 0;
    exp_pkt(1, 8'h42, 8'd0, 8'd0, 8'd0);
    send_pkt(1, 8'h42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    drain(1'b0);
    beat(8'h11, 1'b0, 1'b0);
    chk("stray_discarded", 32'(o_valid), 32'd0);
    exp_pkt(2, 8'd1, 8'd2, 8'd0, 8'd0);
    beat(8'd9, 1'b1, 1'b0);
    beat(8'd8, 1'b0, 1'b0);
    beat(8'd2, 1'b1, 1'b0);
    beat(8'd1, 1'b0, 1'b1);
    chk("restart_valid", 32'(o_valid), 32'd1);
    drain(1'b0);

    // Signedness of comparison
`ifdef PKT_SORTER_SIGNED_EN
    exp_pkt(3, 8'h80, 8'hFF, 8'h01, 8'd0);
`else
    exp_pkt(3, 8'h01, 8'h80, 8'hFF, 8'd0);
`endif
    send_pkt(3, 8'h01, 8'hFF, 8'h80, 8'd0, 8'd0, 8'd0);
    drain(1'b0);

    // Asynchronous reset mid-drain
    send_pkt(2, 8'd4, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0);
    src_ready = 1'b0;
    #2 srst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_len", 32'(o_len), 32'd0);
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    chk("post_rst_ready", 32'(o_ready), 32'd1);
    src_ready = 1'b1;
    exp_pkt(2, 8'd1, 8'd2, 8'd0, 8'd0);
    send_pkt(2, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
